e2_out_monitor: RTL and testbench

- Downstream observer for the e2 controller's 18-bit Moore/Mealy output bus (y1..y18).
- Classifies each sampled output vector against the e2 legal output set and emits a compact 5-bit code.
- Counts output activity and raises sticky alarms when it sees:
  - an illegal pattern, or
  - a suppressed-output run (consecutive all-zero vectors) after the controller has become active.
- Used to detect output-suppression payloads and faulty locked configurations.

---
 rtl/e2_out_monitor.sv | 204 ++++++++++++++++++++
 tb/tb_e2_out_monitor.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/e2_out_monitor.sv
// e2_out_monitor: observes the e2 controller's 18-bit output bus (y1..y18),
// classifies each sampled vector against the legal e2 output set, counts
// legal activity and raises sticky alarms on illegal patterns or on a
// suppressed-output (all-zero) run after the controller has become active.
module e2_out_monitor #(
    parameter int unsigned ZERO_LIMIT = 8,
    parameter int unsigned RUN_W      = 8,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sample_en,
    input  logic [17:0]      y_vec,
    input  logic             clr,
    output logic [4:0]       code,
    output logic             code_valid,
    output logic [CNT_W-1:0] act_count,
    output logic [RUN_W-1:0] zero_run,
    output logic             stall_alarm,
    output logic             illegal_alarm,
    output logic [17:0]      illegal_vec,
    output logic [1:0]       mon_state
);

    typedef enum logic [1:0] {
        ST_ARMED = 2'd0,
        ST_RUN   = 2'd1,
        ST_ALARM = 2'd2
    } mon_state_t;

    localparam logic [4:0] CODE_ILLEGAL = 5'd31;

    mon_state_t       r_state;
    mon_state_t       w_state_next;

    logic [4:0]       r_code;
    logic             r_code_valid;
    logic [CNT_W-1:0] r_act_count;
    logic [RUN_W-1:0] r_zero_run;
    logic             r_stall_alarm;
    logic             r_illegal_alarm;
    logic [17:0]      r_illegal_vec;

    logic [4:0]       w_class;
    logic             w_accept;
    logic             w_is_zero;
    logic             w_is_illegal;
    logic             w_is_legal_nz;
    logic [RUN_W-1:0] w_zr_inc;
    logic             w_stall_hit;
    logic             w_act_inc;

    // Exact-match classification of the output vector; anything else is illegal.
    always_comb begin
        w_class = CODE_ILLEGAL;
        case (y_vec)
            18'h00000: w_class = 5'd0;   // all zero
            18'h00001: w_class = 5'd1;   // y1
            18'h00002: w_class = 5'd2;   // y2
            18'h00004: w_class = 5'd3;   // y3
            18'h00008: w_class = 5'd4;   // y4
            18'h00010: w_class = 5'd5;   // y5
            18'h00020: w_class = 5'd6;   // y6
            18'h000C0: w_class = 5'd7;   // y7,y8
            18'h10080: w_class = 5'd8;   // y8,y17
            18'h00D00: w_class = 5'd9;   // y9,y11,y12
            18'h00200: w_class = 5'd10;  // y10
            18'h00C01: w_class = 5'd11;  // y1,y11,y12
            18'h20800: w_class = 5'd12;  // y12,y18
            18'h01000: w_class = 5'd13;  // y13
            18'h02000: w_class = 5'd14;  // y14
            18'h04000: w_class = 5'd15;  // y15
            18'h08000: w_class = 5'd16;  // y16
            default:   w_class = CODE_ILLEGAL;
        endcase
    end

    // Sample qualification and derived per-sample conditions.
    always_comb begin
        w_accept      = sample_en & ~clr;
        w_is_zero     = (w_class == 5'd0);
        w_is_illegal  = (w_class == CODE_ILLEGAL);
        w_is_legal_nz = ~w_is_zero & ~w_is_illegal;
        w_zr_inc      = (r_zero_run == '1) ? r_zero_run : r_zero_run + 1'b1;
        w_stall_hit   = w_accept & (r_state == ST_RUN) & w_is_zero
                        & (w_zr_inc == RUN_W'(ZERO_LIMIT));
        w_act_inc     = w_accept & w_is_legal_nz & (r_state != ST_ALARM)
                        & (r_act_count != '1);
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= ST_ARMED;
        else
            r_state <= w_state_next;
    end

    // FSM next-state logic; clr always returns the monitor to ARMED.
    always_comb begin
        w_state_next = r_state;
        if (clr) begin
            w_state_next = ST_ARMED;
        end else if (w_accept) begin
            case (r_state)
                ST_ARMED: begin
                    if (w_is_illegal)
                        w_state_next = ST_ALARM;
                    else if (w_is_legal_nz)
                        w_state_next = ST_RUN;
                end
                ST_RUN: begin
                    if (w_is_illegal || w_stall_hit)
                        w_state_next = ST_ALARM;
                end
                ST_ALARM: w_state_next = ST_ALARM;
                default:  w_state_next = ST_ARMED;
            endcase
        end
    end

    // FSM output decode.
    always_comb begin
        mon_state = r_state;
    end

    // Classification code and its one-cycle valid pulse; code holds otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_code       <= '0;
            r_code_valid <= 1'b0;
        end else begin
            r_code_valid <= w_accept;
            if (w_accept)
                r_code <= w_class;
        end
    end

    // Saturating activity counter of legal non-zero samples, frozen in ALARM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_act_count <= '0;
        else if (clr)
            r_act_count <= '0;
        else if (w_act_inc)
            r_act_count <= r_act_count + 1'b1;
    end

    // Zero-run counter: only tracks in RUN; any non-zero sample (legal or not) clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_zero_run <= '0;
        else if (clr)
            r_zero_run <= '0;
        else if (w_accept && (r_state == ST_RUN)) begin
            if (w_is_zero)
                r_zero_run <= w_zr_inc;
            else
                r_zero_run <= '0;
        end
    end

    // Sticky stall alarm when the zero run reaches its limit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_stall_alarm <= 1'b0;
        else if (clr)
            r_stall_alarm <= 1'b0;
        else if (w_stall_hit)
            r_stall_alarm <= 1'b1;
    end

    // Sticky illegal-pattern alarm; set in any state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_illegal_alarm <= 1'b0;
        else if (clr)
            r_illegal_alarm <= 1'b0;
        else if (w_accept && w_is_illegal)
            r_illegal_alarm <= 1'b1;
    end

    // Capture only the first illegal vector; frozen once ALARM is reached.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_illegal_vec <= '0;
        else if (clr)
            r_illegal_vec <= '0;
        else if (w_accept && w_is_illegal && !r_illegal_alarm && (r_state != ST_ALARM))
            r_illegal_vec <= y_vec;
    end

    // Output drive from registers.
    always_comb begin
        code          = r_code;
        code_valid    = r_code_valid;
        act_count     = r_act_count;
        zero_run      = r_zero_run;
        stall_alarm   = r_stall_alarm;
        illegal_alarm = r_illegal_alarm;
        illegal_vec   = r_illegal_vec;
    end

endmodule

// File: tb/tb_e2_out_monitor.sv
// Directed testbench for e2_out_monitor with hand-computed expectations.
module tb_e2_out_monitor;

    logic        clk;
    logic        rst;
    logic        sample_en;
    logic [17:0] y_vec;
    logic        clr;
    logic [4:0]  code;
    logic        code_valid;
    logic [15:0] act_count;
    logic [7:0]  zero_run;
    logic        stall_alarm;
    logic        illegal_alarm;
    logic [17:0] illegal_vec;
    logic [1:0]  mon_state;

    int unsigned n_chk;
    int unsigned n_err;

    e2_out_monitor #(
        .ZERO_LIMIT (8),
        .RUN_W      (8),
        .CNT_W      (16)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .sample_en     (sample_en),
        .y_vec         (y_vec),
        .clr           (clr),
        .code          (code),
        .code_valid    (code_valid),
        .act_count     (act_count),
        .zero_run      (zero_run),
        .stall_alarm   (stall_alarm),
        .illegal_alarm (illegal_alarm),
        .illegal_vec   (illegal_vec),
        .mon_state     (mon_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard time limit so the run always ends.
    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One accepted sample; returns #1 after the capturing edge.
    task automatic do_sample(input logic [17:0] v);
        @(negedge clk);
        sample_en = 1'b1;
        y_vec     = v;
        @(posedge clk);
        #1;
        sample_en = 1'b0;
    endtask

    task automatic do_clr();
        @(negedge clk);
        clr       = 1'b1;
        sample_en = 1'b0;
        @(posedge clk);
        #1;
        clr = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".code"},    {27'd0, code}, 32'd0);
        chk({tag, ".valid"},   {31'd0, code_valid}, 32'd0);
        chk({tag, ".act"},     {16'd0, act_count}, 32'd0);
        chk({tag, ".zrun"},    {24'd0, zero_run}, 32'd0);
        chk({tag, ".stall"},   {31'd0, stall_alarm}, 32'd0);
        chk({tag, ".illegal"}, {31'd0, illegal_alarm}, 32'd0);
        chk({tag, ".ivec"},    {14'd0, illegal_vec}, 32'd0);
        chk({tag, ".state"},   {30'd0, mon_state}, 32'd0);
    endtask

    initial begin
        n_chk     = 0;
        n_err     = 0;
        rst       = 1'b1;
        sample_en = 1'b0;
        y_vec     = '0;
        clr       = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        // Basic classification and ARMED -> RUN
        do_sample(18'h00000);
        chk("s0.code",  {27'd0, code}, 32'd0);
        chk("s0.valid", {31'd0, code_valid}, 32'd1);
        chk("s0.state", {30'd0, mon_state}, 32'd0);
        chk("s0.zrun",  {24'd0, zero_run}, 32'd0);
        do_sample(18'h00001);
        chk("s1.code",  {27'd0, code}, 32'd1);
        chk("s1.state", {30'd0, mon_state}, 32'd1);
        chk("s1.act",   {16'd0, act_count}, 32'd1);
        do_sample(18'h20800);
        chk("s2.code",  {27'd0, code}, 32'd12);
        chk("s2.valid", {31'd0, code_valid}, 32'd1);
        chk("s2.act",   {16'd0, act_count}, 32'd2);
        @(posedge clk);
        #1;
        chk("idle.valid", {31'd0, code_valid}, 32'd0);
        chk("idle.code",  {27'd0, code}, 32'd12);

        // Zero run to stall alarm
        for (int i = 1; i <= 8; i++) begin
            do_sample(18'h00000);
            chk($sformatf("zr%0d.zrun", i), {24'd0, zero_run}, i);
            chk($sformatf("zr%0d.stall", i), {31'd0, stall_alarm}, (i == 8) ? 32'd1 : 32'd0);
            chk($sformatf("zr%0d.state", i), {30'd0, mon_state}, (i == 8) ? 32'd2 : 32'd1);
        end
        do_sample(18'h00008);
        chk("alarm.code", {27'd0, code}, 32'd4);
        chk("alarm.act",  {16'd0, act_count}, 32'd2);
        chk("alarm.zrun", {24'd0, zero_run}, 32'd8);

        // clr wins over a simultaneous sample
        @(negedge clk);
        clr       = 1'b1;
        sample_en = 1'b1;
        y_vec     = 18'h00010;
        @(posedge clk);
        #1;
        clr       = 1'b0;
        sample_en = 1'b0;
        chk("clr.valid",   {31'd0, code_valid}, 32'd0);
        chk("clr.code",    {27'd0, code}, 32'd4);
        chk("clr.act",     {16'd0, act_count}, 32'd0);
        chk("clr.zrun",    {24'd0, zero_run}, 32'd0);
        chk("clr.stall",   {31'd0, stall_alarm}, 32'd0);
        chk("clr.illegal", {31'd0, illegal_alarm}, 32'd0);
        chk("clr.state",   {30'd0, mon_state}, 32'd0);

        // RUN: zero then legal clears run; illegal captures first vector
        do_sample(18'h00001);
        chk("r.state", {30'd0, mon_state}, 32'd1);
        do_sample(18'h00000);
        chk("r.zrun1", {24'd0, zero_run}, 32'd1);
        do_sample(18'h00010);
        chk("r.code5", {27'd0, code}, 32'd5);
        chk("r.zrun0", {24'd0, zero_run}, 32'd0);
        chk("r.act2",  {16'd0, act_count}, 32'd2);
        do_sample(18'h00000);
        do_sample(18'h00003);
        chk("ill.code",  {27'd0, code}, 32'd31);
        chk("ill.alarm", {31'd0, illegal_alarm}, 32'd1);
        chk("ill.vec",   {14'd0, illegal_vec}, 32'h00003);
        chk("ill.state", {30'd0, mon_state}, 32'd2);
        chk("ill.zrun",  {24'd0, zero_run}, 32'd0);
        chk("ill.act",   {16'd0, act_count}, 32'd2);
        chk("ill.stall", {31'd0, stall_alarm}, 32'd0);
        do_sample(18'h30000);
        chk("ill2.code", {27'd0, code}, 32'd31);
        chk("ill2.vec",  {14'd0, illegal_vec}, 32'h00003);

        // Zero samples while ARMED are ignored
        do_clr();
        for (int i = 0; i < 20; i++) do_sample(18'h00000);
        chk("armed.zrun",  {24'd0, zero_run}, 32'd0);
        chk("armed.stall", {31'd0, stall_alarm}, 32'd0);
        chk("armed.state", {30'd0, mon_state}, 32'd0);

        // Illegal straight from ARMED
        do_sample(18'h00D01);
        chk("aill.state", {30'd0, mon_state}, 32'd2);
        chk("aill.vec",   {14'd0, illegal_vec}, 32'h00D01);

        // Activity counter saturation with continuous y13 samples
        do_clr();
        @(negedge clk);
        sample_en = 1'b1;
        y_vec     = 18'h01000;
        repeat (65534) @(posedge clk);
        #1;
        chk("sat.fffe", {16'd0, act_count}, 32'h0000FFFE);
        repeat (6) @(posedge clk);
        #1;
        sample_en = 1'b0;
        chk("sat.ffff",  {16'd0, act_count}, 32'h0000FFFF);
        chk("sat.code",  {27'd0, code}, 32'd13);
        chk("sat.state", {30'd0, mon_state}, 32'd1);

        // Asynchronous reset mid-operation
        do_sample(18'h00003);
        chk("pre.ill", {31'd0, illegal_alarm}, 32'd1);
        @(negedge clk);
        sample_en = 1'b1;
        y_vec     = 18'h00003;
        #2;
        rst = 1'b1;
        #1;
        chk_all_zero("arst");
        sample_en = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
